// File: rtl/user_key_ctrl_pkg.sv
// user_key_pkg: shared types and helpers for the user key controller.
// Holds the default word width, the controller state enum and the
// mix/rotate helper functions used by the datapath.
package user_key_pkg;

   localparam int USER_KEY_DATA_W    = 32;
   localparam int USER_KEY_MAX_WORDS = 16;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ARMED = 2'd1,
      DRAIN = 2'd2
   } state_e;

   // Mix one data word with the key.
   function automatic logic [USER_KEY_DATA_W-1:0] key_mix(
      input logic [USER_KEY_DATA_W-1:0] data,
      input logic [USER_KEY_DATA_W-1:0] key
   );
      return data ^ key;
   endfunction

   // Rotate a key word left by one bit.
   function automatic logic [USER_KEY_DATA_W-1:0] rotl1(
      input logic [USER_KEY_DATA_W-1:0] key
   );
      return {key[USER_KEY_DATA_W-2:0], key[USER_KEY_DATA_W-1]};
   endfunction

endpackage

// File: rtl/user_key_ctrl_if.sv
// user_key_ctrl_if: key control plus data stream handshake bundle.
// master = the side driving key/data (producer, downstream ready);
// slave  = the user_key_ctrl block itself.
interface user_key_ctrl_if #(
   parameter int DATA_W    = 32,
   parameter int MAX_WORDS = 16
);
   localparam int CNT_W = $clog2(MAX_WORDS + 1);

   logic [DATA_W-1:0] key_in;
   logic              key_load;
   logic              key_clear;
   logic [DATA_W-1:0] in_data;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;
   logic              key_armed;
   logic [CNT_W-1:0]  words_left;
   logic              err_no_key;

   modport master (
      output key_in, key_load, key_clear, in_data, in_valid, out_ready,
      input  in_ready, out_data, out_valid, key_armed, words_left, err_no_key
   );

   modport slave (
      input  key_in, key_load, key_clear, in_data, in_valid, out_ready,
      output in_ready, out_data, out_valid, key_armed, words_left, err_no_key
   );

endinterface

// File: rtl/user_key_ctrl_key_mix_stage.sv
// key_mix_stage: single output register with valid/ready handshake.
// The key mix is applied on the input side, so out_data holds the
// already-mixed word and stays stable while back-pressured.
module key_mix_stage
   import user_key_pkg::*;
#(
   parameter int DATA_W = USER_KEY_DATA_W
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              accept,
   input  logic [DATA_W-1:0] in_data,
   input  logic [DATA_W-1:0] key,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid
);

   logic [DATA_W-1:0] mixed_s;
   logic [DATA_W-1:0] out_data_r;
   logic              out_valid_r;

   // Mix the incoming word with the key that is current this cycle.
   always_comb begin
      mixed_s = key_mix(in_data, key);
   end

   // Output register: load on accept, drop valid on a bare consume, else hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_data_r  <= {DATA_W{1'b0}};
         out_valid_r <= 1'b0;
      end else if (accept) begin
         out_data_r  <= mixed_s;
         out_valid_r <= 1'b1;
      end else if (out_ready) begin
         out_data_r  <= out_data_r;
         out_valid_r <= 1'b0;
      end else begin
         out_data_r  <= out_data_r;
         out_valid_r <= out_valid_r;
      end
   end

   assign out_data  = out_data_r;
   assign out_valid = out_valid_r;

endmodule

// File: rtl/user_key_ctrl.sv
// user_key_ctrl: key-lifetime manager and sequencer for the key-mixing
// datapath. Holds a user key, counts its remaining uses, and mixes each
// accepted word into a registered output stage (key_mix_stage).
// Optional build macro USER_KEY_ROTATE_EN: rotate the key left by one bit
// after every accepted word (a key_load in the same cycle takes priority).
// The package helpers are sized by USER_KEY_DATA_W, so DATA_W is expected
// to stay at that width.
module user_key_ctrl
   import user_key_pkg::*;
#(
   parameter int DATA_W    = USER_KEY_DATA_W,
   parameter int MAX_WORDS = USER_KEY_MAX_WORDS
)(
   input  logic           clk,
   input  logic           rst,
   user_key_ctrl_if.slave bus
);

   localparam int CNT_W = $clog2(MAX_WORDS + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WORDS);
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_e            state_r;
   state_e            state_s;
   logic [DATA_W-1:0] key_r;
   logic [DATA_W-1:0] key_s;
   logic [CNT_W-1:0]  words_left_r;
   logic [CNT_W-1:0]  words_left_s;
   logic              err_r;
   logic              in_ready_s;
   logic              accept_s;
   logic              last_word_s;
   logic [DATA_W-1:0] out_data_s;
   logic              out_valid_s;

   // Input handshake: take a word only when armed, not clearing, and the
   // output register is empty or being drained this cycle.
   always_comb begin
      in_ready_s = 1'b0;
      if ((state_r == ARMED) && !bus.key_clear && (!out_valid_s || bus.out_ready)) begin
         in_ready_s = 1'b1;
      end else begin
         in_ready_s = 1'b0;
      end
      accept_s    = bus.in_valid & in_ready_s;
      last_word_s = accept_s & (words_left_r == CNT_ONE);
   end

   // Next-state logic; clear beats load, and a reload beats expiry.
   always_comb begin
      state_s = state_r;
      case (state_r)
         EMPTY: begin
            if (bus.key_load && !bus.key_clear) begin
               state_s = ARMED;
            end else begin
               state_s = EMPTY;
            end
         end
         ARMED: begin
            if (bus.key_clear) begin
               state_s = DRAIN;
            end else if (bus.key_load) begin
               state_s = ARMED;
            end else if (last_word_s) begin
               state_s = DRAIN;
            end else begin
               state_s = ARMED;
            end
         end
         DRAIN: begin
            if (bus.key_load && !bus.key_clear) begin
               state_s = ARMED;
            end else if (!out_valid_s || bus.out_ready) begin
               state_s = EMPTY;
            end else begin
               state_s = DRAIN;
            end
         end
         default: begin
            state_s = EMPTY;
         end
      endcase
   end

   // Key and use-counter update; an accepted word always sees the old key.
   always_comb begin
      key_s        = key_r;
      words_left_s = words_left_r;
      if (bus.key_clear) begin
         key_s        = {DATA_W{1'b0}};
         words_left_s = {CNT_W{1'b0}};
      end else if (bus.key_load) begin
         key_s        = bus.key_in;
         words_left_s = CNT_MAX;
      end else if (accept_s) begin
`ifdef USER_KEY_ROTATE_EN
         key_s        = rotl1(key_r);
`else
         key_s        = key_r;
`endif
         words_left_s = words_left_r - CNT_ONE;
      end else begin
         key_s        = key_r;
         words_left_s = words_left_r;
      end
   end

   // Control registers and the registered no-key error pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= EMPTY;
         key_r        <= {DATA_W{1'b0}};
         words_left_r <= {CNT_W{1'b0}};
         err_r        <= 1'b0;
      end else begin
         state_r      <= state_s;
         key_r        <= key_s;
         words_left_r <= words_left_s;
         err_r        <= bus.in_valid & (state_r != ARMED);
      end
   end

   key_mix_stage #(
      .DATA_W (DATA_W)
   ) u_mix_stage (
      .clk       (clk),
      .rst       (rst),
      .accept    (accept_s),
      .in_data   (bus.in_data),
      .key       (key_r),
      .out_ready (bus.out_ready),
      .out_data  (out_data_s),
      .out_valid (out_valid_s)
   );

   assign bus.in_ready   = in_ready_s;
   assign bus.out_data   = out_data_s;
   assign bus.out_valid  = out_valid_s;
   assign bus.key_armed  = (state_r == ARMED);
   assign bus.words_left = words_left_r;
   assign bus.err_no_key = err_r;

endmodule

// File: tb/tb_user_key_ctrl.sv
// Self-checking bench for user_key_ctrl: directed scenarios plus a random
// run, all compared against a transaction-level reference model.
module tb_user_key_ctrl;
   import user_key_pkg::*;

   localparam int DW = 32;
   localparam int MW = 16;
   localparam int CW = $clog2(MW + 1);

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   user_key_ctrl_if #(.DATA_W(DW), .MAX_WORDS(MW)) bus ();

   user_key_ctrl #(.DATA_W(DW), .MAX_WORDS(MW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // reference model: is a key usable, which key, uses left, output slot
   bit          m_armed;
   logic [31:0] m_key;
   logic [CW-1:0] m_left;
   bit          m_ov;
   logic [31:0] m_od;
   bit          m_err;

   int tests = 0;
   int fails = 0;
   int dut_acc = 0;

   function automatic bit m_in_ready();
      return m_armed && !bus.key_clear && (!m_ov || bus.out_ready);
   endfunction

   // drive one cycle of inputs, advance the model over the clock edge
   task automatic apply(input logic r, input logic kl, input logic kc,
                        input logic [31:0] ki, input logic iv,
                        input logic [31:0] id, input logic ordy);
      bit acc;
      bit old_armed;
      logic [CW-1:0] old_left;
      @(negedge clk);
      rst           = r;
      bus.key_load  = kl;
      bus.key_clear = kc;
      bus.key_in    = ki;
      bus.in_valid  = iv;
      bus.in_data   = id;
      bus.out_ready = ordy;
      #1;
      acc = iv && m_in_ready();
      if (iv && bus.in_ready) dut_acc++;
      @(posedge clk);
      old_armed = m_armed;
      old_left  = m_left;
      if (r) begin
         m_armed = 0; m_key = 32'h0; m_left = '0; m_ov = 0; m_od = 32'h0; m_err = 0;
      end else begin
         m_err = iv && !old_armed;
         if (acc) begin
            m_od = id ^ m_key;
            m_ov = 1;
         end else if (ordy) begin
            m_ov = 0;
         end
         if (kc) begin
            m_armed = 0; m_key = 32'h0; m_left = '0;
         end else if (kl) begin
            m_armed = 1; m_key = ki; m_left = CW'(MW);
         end else if (acc) begin
            m_left = old_left - 1'b1;
            if (old_left == 1) m_armed = 0;
`ifdef USER_KEY_ROTATE_EN
            m_key = (m_key << 1) | (m_key >> 31);
`endif
         end
      end
      #1;
   endtask

   task automatic idle();
      apply(0, 0, 0, 32'h0, 0, 32'h0, 1);
   endtask

   task automatic test_reset();
      apply(1, 0, 0, 32'h0, 0, 32'h0, 0);
      apply(1, 0, 0, 32'h0, 0, 32'h0, 0);
      tests++; if (bus.out_data !== 32'h0) begin fails++; $display("FAIL reset_out_data got %h want %h", bus.out_data, 32'h0); end
      tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
      tests++; if (bus.err_no_key !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", bus.err_no_key); end
      tests++; if (bus.key_armed !== 1'b0) begin fails++; $display("FAIL reset_armed got %b want 0", bus.key_armed); end
      tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got %b want 0", bus.in_ready); end
      tests++; if (bus.words_left !== 5'd0) begin fails++; $display("FAIL reset_words_left got %0d want 0", bus.words_left); end
   endtask

   task automatic test_no_key();
      for (int i = 0; i < 3; i++) begin
         apply(0, 0, 0, 32'h0, 1, $urandom, 1);
         tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL nokey_in_ready got %b want 0", bus.in_ready); end
         tests++; if (bus.err_no_key !== 1'b1) begin fails++; $display("FAIL nokey_err got %b want 1", bus.err_no_key); end
         tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL nokey_out_valid got %b want 0", bus.out_valid); end
      end
      idle();
      tests++; if (bus.err_no_key !== 1'b0) begin fails++; $display("FAIL nokey_err_drop got %b want 0", bus.err_no_key); end
   endtask

   task automatic test_basic_mix();
      apply(0, 1, 0, 32'hC000_0003, 0, 32'h0, 1);
      tests++; if (bus.key_armed !== 1'b1) begin fails++; $display("FAIL basic_armed got %b want 1", bus.key_armed); end
      apply(0, 0, 0, 32'h0, 1, 32'hFFFF_FFFF, 1);
      tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL basic_out_valid got %b want 1", bus.out_valid); end
      tests++; if (bus.out_data !== 32'h3FFF_FFFC) begin fails++; $display("FAIL basic_out_data got %h want %h", bus.out_data, 32'h3FFF_FFFC); end
      tests++; if (bus.words_left !== 5'd15) begin fails++; $display("FAIL basic_words_left got %0d want 15", bus.words_left); end
      idle();
      tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL basic_drain got %b want 0", bus.out_valid); end
   endtask

   task automatic test_reload();
      apply(0, 1, 0, 32'h0000_0018, 0, 32'h0, 1);
      apply(0, 0, 0, 32'h0, 1, 32'hFFFF_FFFF, 1);
      tests++; if (bus.out_data !== 32'hFFFF_FFE7) begin fails++; $display("FAIL reload_out_data got %h want %h", bus.out_data, 32'hFFFF_FFE7); end
`ifdef USER_KEY_ROTATE_EN
      apply(0, 1, 0, 32'hC000_0003, 0, 32'h0, 1);
      apply(0, 0, 0, 32'h0, 1, 32'hFFFF_FFFF, 1);
      tests++; if (bus.out_data !== 32'h3FFF_FFFC) begin fails++; $display("FAIL rotate_word0 got %h want %h", bus.out_data, 32'h3FFF_FFFC); end
      apply(0, 0, 0, 32'h0, 1, 32'hFFFF_FFFF, 1);
      tests++; if (bus.out_data !== 32'h7FFF_FFF8) begin fails++; $display("FAIL rotate_word1 got %h want %h", bus.out_data, 32'h7FFF_FFF8); end
`endif
      idle();
   endtask

   task automatic test_expiry();
      apply(0, 1, 0, $urandom, 0, 32'h0, 1);
      dut_acc = 0;
      for (int i = 0; i < MW + 1; i++) begin
         apply(0, 0, 0, 32'h0, 1, $urandom, 1);
         tests++; if (bus.out_data !== m_od) begin fails++; $display("FAIL expiry_data[%0d] got %h want %h", i, bus.out_data, m_od); end
         tests++; if (bus.words_left !== m_left) begin fails++; $display("FAIL expiry_left[%0d] got %0d want %0d", i, bus.words_left, m_left); end
         if (i == MW - 1) begin
            tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL expiry_in_ready got %b want 0", bus.in_ready); end
            tests++; if (bus.key_armed !== 1'b0) begin fails++; $display("FAIL expiry_armed got %b want 0", bus.key_armed); end
            tests++; if (bus.words_left !== 5'd0) begin fails++; $display("FAIL expiry_zero got %0d want 0", bus.words_left); end
            tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL expiry_last_valid got %b want 1", bus.out_valid); end
         end
         if (i == MW) begin
            tests++; if (bus.err_no_key !== 1'b1) begin fails++; $display("FAIL expiry_err got %b want 1", bus.err_no_key); end
            tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL expiry_drained got %b want 0", bus.out_valid); end
         end
      end
      tests++; if (dut_acc !== MW) begin fails++; $display("FAIL expiry_accepts got %0d want %0d", dut_acc, MW); end
      idle();
      tests++; if (bus.err_no_key !== 1'b0) begin fails++; $display("FAIL expiry_err_drop got %b want 0", bus.err_no_key); end
   endtask

   task automatic test_backpressure();
      logic [31:0] k;
      logic [31:0] w;
      k = $urandom;
      w = $urandom;
      apply(0, 1, 0, k, 0, 32'h0, 1);
      apply(0, 0, 0, 32'h0, 1, w, 0);
      for (int i = 0; i < 5; i++) begin
         apply(0, 0, 0, 32'h0, 1, $urandom, 0);
         tests++; if (bus.out_data !== (w ^ k)) begin fails++; $display("FAIL bp_data[%0d] got %h want %h", i, bus.out_data, w ^ k); end
         tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL bp_valid[%0d] got %b want 1", i, bus.out_valid); end
         tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready[%0d] got %b want 0", i, bus.in_ready); end
         tests++; if (bus.words_left !== 5'(MW - 1)) begin fails++; $display("FAIL bp_left[%0d] got %0d want %0d", i, bus.words_left, MW - 1); end
      end
      idle();
      tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL bp_release got %b want 0", bus.out_valid); end
   endtask

   task automatic test_simultaneous();
      logic [31:0] ka, kb, x, y, z;
      ka = $urandom; kb = $urandom; x = $urandom; y = $urandom; z = $urandom;
      apply(0, 1, 1, ka, 0, 32'h0, 1);
      tests++; if (bus.key_armed !== 1'b0) begin fails++; $display("FAIL simul_clr_armed got %b want 0", bus.key_armed); end
      tests++; if (bus.words_left !== 5'd0) begin fails++; $display("FAIL simul_clr_left got %0d want 0", bus.words_left); end
      apply(0, 1, 0, ka, 0, 32'h0, 1);
      apply(0, 0, 0, 32'h0, 1, x, 1);
      apply(0, 1, 0, kb, 1, y, 1);
      tests++; if (bus.out_data !== (y ^ ka)) begin fails++; $display("FAIL simul_old_key got %h want %h", bus.out_data, y ^ ka); end
      tests++; if (bus.words_left !== 5'(MW)) begin fails++; $display("FAIL simul_reload_left got %0d want %0d", bus.words_left, MW); end
      apply(0, 0, 0, 32'h0, 1, z, 1);
      tests++; if (bus.out_data !== (z ^ kb)) begin fails++; $display("FAIL simul_new_key got %h want %h", bus.out_data, z ^ kb); end
      tests++; if (bus.words_left !== 5'(MW - 1)) begin fails++; $display("FAIL simul_new_left got %0d want %0d", bus.words_left, MW - 1); end
      idle();
   endtask

   task automatic test_reset_mid();
      apply(0, 1, 0, $urandom, 0, 32'h0, 1);
      apply(0, 0, 0, 32'h0, 1, $urandom | 32'h1, 0);
      tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL rstmid_pre_valid got %b want 1", bus.out_valid); end
      apply(1, 0, 0, 32'h0, 0, 32'h0, 0);
      tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL rstmid_valid got %b want 0", bus.out_valid); end
      tests++; if (bus.out_data !== 32'h0) begin fails++; $display("FAIL rstmid_data got %h want 0", bus.out_data); end
      tests++; if (bus.key_armed !== 1'b0) begin fails++; $display("FAIL rstmid_armed got %b want 0", bus.key_armed); end
      tests++; if (bus.words_left !== 5'd0) begin fails++; $display("FAIL rstmid_left got %0d want 0", bus.words_left); end
      tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL rstmid_in_ready got %b want 0", bus.in_ready); end
      idle();
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         apply($urandom_range(0, 99) == 0, $urandom_range(0, 11) == 0,
               $urandom_range(0, 24) == 0, $urandom, $urandom_range(0, 3) != 0,
               $urandom, $urandom_range(0, 3) != 0);
         tests++; if (bus.out_valid !== m_ov) begin fails++; $display("FAIL rnd_valid[%0d] got %b want %b", i, bus.out_valid, m_ov); end
         tests++; if (bus.out_data !== m_od) begin fails++; $display("FAIL rnd_data[%0d] got %h want %h", i, bus.out_data, m_od); end
         tests++; if (bus.key_armed !== m_armed) begin fails++; $display("FAIL rnd_armed[%0d] got %b want %b", i, bus.key_armed, m_armed); end
         tests++; if (bus.words_left !== m_left) begin fails++; $display("FAIL rnd_left[%0d] got %0d want %0d", i, bus.words_left, m_left); end
         tests++; if (bus.err_no_key !== m_err) begin fails++; $display("FAIL rnd_err[%0d] got %b want %b", i, bus.err_no_key, m_err); end
         tests++; if (bus.in_ready !== m_in_ready()) begin fails++; $display("FAIL rnd_in_ready[%0d] got %b want %b", i, bus.in_ready, m_in_ready()); end
      end
   endtask

   initial begin
      rst           = 1'b1;
      bus.key_in    = 32'h0;
      bus.key_load  = 1'b0;
      bus.key_clear = 1'b0;
      bus.in_data   = 32'h0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      m_armed = 0; m_key = 32'h0; m_left = '0; m_ov = 0; m_od = 32'h0; m_err = 0;
      test_reset();
      test_no_key();
      test_basic_mix();
      test_reload();
      test_expiry();
      test_backpressure();
      test_simultaneous();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
